sblk_row_ctrl: RTL and testbench

Controller for a row of N_ROW superblocks.
- Accepts one instruction stream carrying a per-instruction row mask and issues inst_en / inst_data to the selected superblocks.
- Keeps a per-row busy scoreboard driven by status_sblk.
- Distributes one activation stream to the rows in broadcast or round-robin scatter mode through a registered output stage with per-row handshakes.
- Sits between the top-level sequencer and the superblock row; its outputs connect directly to the row's act_data_in*, inst_* and status_sblk ports.

---
 rtl/sblk_row_pkg.sv | 15 +
 rtl/sblk_row_act_dist.sv | 51 +++++
 rtl/sblk_row_ctrl.sv | 111 +++++++++++
 tb/tb_sblk_row_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sblk_row_pkg.sv
// sblk_row_pkg: shared types and the round-robin helper for the superblock row controller.
package sblk_row_pkg;
  typedef enum logic {ACT_BCAST, ACT_SCATTER} act_mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GUARD} state_e;
  localparam int RR_W = 5;
  // Next set bit of mask strictly after cur, cyclically over n rows; cur if mask is empty.
  function automatic logic [RR_W-1:0] next_rr(input logic [31:0] mask, input logic [RR_W-1:0] cur, input int n);
    int idx;
    next_rr = cur;
    for (int k = 32; k >= 1; k--) begin
      idx = (int'(cur) + k) % n;
      if (k <= n && mask[idx]) next_rr = RR_W'(idx);
    end
  endfunction
endpackage

// File: rtl/sblk_row_act_dist.sv
// sblk_row_act_dist: activation config, round-robin pointer and registered per-row output stage.
module sblk_row_act_dist
  import sblk_row_pkg::*;
#(
  parameter int N_ROW   = 7,
  parameter int WID_ACT = 16
) (
  input  logic                       clk_h,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic                       cfg_act_mode,
  input  logic [N_ROW-1:0]           cfg_act_mask,
  input  logic [2*WID_ACT-1:0]       act_in,
  input  logic                       act_in_vld,
  output logic                       act_in_rdy,
  output logic [2*WID_ACT*N_ROW-1:0] act_data_in,
  output logic [N_ROW-1:0]           act_data_in_vld,
  input  logic [N_ROW-1:0]           act_data_in_req
);
  act_mode_e            mode_q;
  logic [N_ROW-1:0]     mask_q, vld_q, vld_d;
  logic [RR_W-1:0]      rr_q;
  logic [2*WID_ACT-1:0] data_q;
  logic                 acc, cfg_ok;
  assign act_in_rdy = (mask_q != '0) && ((vld_q & ~act_data_in_req) == '0);
  assign acc = act_in_vld & act_in_rdy;
  assign cfg_ok = cfg_we && (vld_q == '0);
  always_comb vld_d = acc ? (mode_q == ACT_SCATTER ? N_ROW'(1) << rr_q : mask_q) : (vld_q & ~act_data_in_req);
  always_ff @(posedge clk_h) begin
    if (rst) begin
      mode_q <= ACT_BCAST;
      mask_q <= '0;
      rr_q   <= '0;
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (acc) data_q <= act_in;
      // Config is only taken while nothing is pending, so a beat never straddles two configs.
      if (cfg_ok) begin
        mode_q <= act_mode_e'(cfg_act_mode);
        mask_q <= cfg_act_mask;
        rr_q   <= next_rr(32'(cfg_act_mask), RR_W'(N_ROW-1), N_ROW);
      end else if (acc && mode_q == ACT_SCATTER) begin
        rr_q <= next_rr(32'(mask_q), rr_q, N_ROW);
      end
    end
  end
  assign act_data_in = {N_ROW{data_q}};
  assign act_data_in_vld = vld_q;
endmodule

// File: rtl/sblk_row_ctrl.sv
// sblk_row_ctrl: instruction issue FSM, busy scoreboard and activation distribution for a superblock row.
// Optional per-row watchdog enabled with `define SBLK_ROW_WDT_EN.
module sblk_row_ctrl
  import sblk_row_pkg::*;
#(
  parameter int N_ROW     = 7,
  parameter int WID_ACT   = 16,
  parameter int WID_INST  = 14,
  parameter int GUARD_CYC = 4,
  parameter int WID_GUARD = $clog2(GUARD_CYC+1),
  parameter int WDT_CYC   = 65535
) (
  input  logic                       clk_h,
  input  logic                       rst,
  input  logic [WID_INST-1:0]        inst_in,
  input  logic [N_ROW-1:0]           inst_row_mask,
  input  logic                       inst_vld,
  output logic                       inst_rdy,
  output logic [WID_INST*N_ROW-1:0]  inst_data,
  output logic [N_ROW-1:0]           inst_en,
  input  logic [N_ROW-1:0]           status_sblk,
  input  logic                       cfg_we,
  input  logic                       cfg_act_mode,
  input  logic [N_ROW-1:0]           cfg_act_mask,
  input  logic [2*WID_ACT-1:0]       act_in,
  input  logic                       act_in_vld,
  output logic                       act_in_rdy,
  output logic [2*WID_ACT*N_ROW-1:0] act_data_in,
  output logic [N_ROW-1:0]           act_data_in_vld,
  input  logic [N_ROW-1:0]           act_data_in_req,
  output logic [N_ROW-1:0]           row_busy,
  output logic                       all_idle,
  output logic                       done,
  output logic [N_ROW-1:0]           wdt_err
);
  state_e                    state_q;
  logic [WID_GUARD-1:0]      guard_q;
  logic [N_ROW-1:0]          inst_en_q, busy_q, busy_d, wdt_hit;
  logic [WID_INST*N_ROW-1:0] inst_data_q;
  logic                      done_q, acc;
  assign inst_rdy = !rst && state_q == ST_IDLE && ((inst_row_mask & busy_q) == '0);
  assign acc = inst_vld & inst_rdy;
  // Clears are only trusted in IDLE, after the guard has covered status_sblk rise latency.
  always_comb busy_d = ((state_q == ST_IDLE ? busy_q & status_sblk : busy_q) | (acc ? inst_row_mask : '0)) & ~wdt_hit;
  always_ff @(posedge clk_h) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      guard_q     <= '0;
      inst_en_q   <= '0;
      inst_data_q <= '0;
      busy_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= (busy_q != '0) && (busy_d == '0);
      inst_en_q <= '0;
      case (state_q)
        ST_IDLE: if (acc && inst_row_mask != '0) begin
          inst_en_q   <= inst_row_mask;
          inst_data_q <= {N_ROW{inst_in}};
          state_q     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          guard_q <= WID_GUARD'(GUARD_CYC);
          state_q <= ST_GUARD;
        end
        ST_GUARD: if (guard_q == '0) state_q <= ST_IDLE; else guard_q <= guard_q - 1'b1;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign inst_en = inst_en_q;
  assign inst_data = inst_data_q;
  assign row_busy = busy_q;
  assign all_idle = busy_q == '0;
  assign done = done_q;
`ifdef SBLK_ROW_WDT_EN
  localparam int WID_WDT = $clog2(WDT_CYC+1);
  logic [WID_WDT-1:0] wdt_cnt_q [N_ROW];
  logic [N_ROW-1:0]   wdt_err_q;
  for (genvar r = 0; r < N_ROW; r++) begin : g_wdt
    assign wdt_hit[r] = busy_q[r] && wdt_cnt_q[r] == WID_WDT'(WDT_CYC-1);
    always_ff @(posedge clk_h) begin
      if (rst) begin
        wdt_cnt_q[r] <= '0;
        wdt_err_q[r] <= 1'b0;
      end else begin
        wdt_cnt_q[r] <= (busy_q[r] && busy_d[r]) ? wdt_cnt_q[r] + 1'b1 : '0;
        wdt_err_q[r] <= wdt_err_q[r] | wdt_hit[r];
      end
    end
  end
  assign wdt_err = wdt_err_q;
`else
  assign wdt_hit = '0;
  assign wdt_err = '0;
`endif
  sblk_row_act_dist #(.N_ROW(N_ROW), .WID_ACT(WID_ACT)) u_act (
    .clk_h           (clk_h),
    .rst             (rst),
    .cfg_we          (cfg_we),
    .cfg_act_mode    (cfg_act_mode),
    .cfg_act_mask    (cfg_act_mask),
    .act_in          (act_in),
    .act_in_vld      (act_in_vld),
    .act_in_rdy      (act_in_rdy),
    .act_data_in     (act_data_in),
    .act_data_in_vld (act_data_in_vld),
    .act_data_in_req (act_data_in_req)
  );
endmodule

// File: tb/tb_sblk_row_ctrl.sv
// tb_sblk_row_ctrl: directed bench with instruction and per-row activation scoreboards.
module tb_sblk_row_ctrl;
  localparam int N = 7;
  localparam int WA = 16;
  localparam int WI = 14;
  typedef struct packed {logic [N-1:0] mask; logic [WI-1:0] word;} inst_t;
  logic            clk_h = 1'b0, rst = 1'b1;
  logic [WI-1:0]   inst_in = '0;
  logic [N-1:0]    inst_row_mask = '0;
  logic            inst_vld = 1'b0, inst_rdy;
  logic [WI*N-1:0] inst_data;
  logic [N-1:0]    inst_en, status_sblk = '0;
  logic            cfg_we = 1'b0, cfg_act_mode = 1'b0;
  logic [N-1:0]    cfg_act_mask = '0;
  logic [2*WA-1:0] act_in = '0;
  logic            act_in_vld = 1'b0, act_in_rdy;
  logic [2*WA*N-1:0] act_data_in;
  logic [N-1:0]    act_data_in_vld, act_data_in_req = '0;
  logic [N-1:0]    row_busy, wdt_err;
  logic            all_idle, done;
  int checks = 0, failures = 0;
  inst_t inst_q[$];
  logic [2*WA-1:0] exp_q [N][$];
  int order [6] = '{0, 3, 5, 0, 3, 5};
  int done_cnt, sent, busy_cyc;

  sblk_row_ctrl #(.N_ROW(N), .WID_ACT(WA), .WID_INST(WI), .GUARD_CYC(4), .WDT_CYC(20)) dut (
    .clk_h(clk_h), .rst(rst), .inst_in(inst_in), .inst_row_mask(inst_row_mask), .inst_vld(inst_vld),
    .inst_rdy(inst_rdy), .inst_data(inst_data), .inst_en(inst_en), .status_sblk(status_sblk),
    .cfg_we(cfg_we), .cfg_act_mode(cfg_act_mode), .cfg_act_mask(cfg_act_mask), .act_in(act_in),
    .act_in_vld(act_in_vld), .act_in_rdy(act_in_rdy), .act_data_in(act_data_in),
    .act_data_in_vld(act_data_in_vld), .act_data_in_req(act_data_in_req), .row_busy(row_busy),
    .all_idle(all_idle), .done(done), .wdt_err(wdt_err)
  );

  always #5 clk_h = ~clk_h;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  always @(negedge clk_h) if (!rst) begin
    inst_t e;
    if (inst_en != '0) begin
      if (inst_q.size() == 0) chk("inst_unexpected", inst_en, '0);
      else begin
        e = inst_q.pop_front();
        chk("sb_inst_en", inst_en, e.mask);
        chk("sb_inst_data", inst_data, {N{e.word}});
      end
    end
    for (int r = 0; r < N; r++) if (act_data_in_vld[r] && act_data_in_req[r]) begin
      if (exp_q[r].size() == 0) chk($sformatf("act_extra_row%0d", r), act_data_in_vld[r], 1'b0);
      else chk($sformatf("act_data_row%0d", r), act_data_in[r*2*WA +: 2*WA], exp_q[r].pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    @(negedge clk_h);
    chk("rst_inst_en", inst_en, '0);
    chk("rst_row_busy", row_busy, '0);
    chk("rst_all_idle", all_idle, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_inst_rdy", inst_rdy, 1'b0);
    chk("rst_act_rdy", act_in_rdy, 1'b0);
    chk("rst_act_vld", act_data_in_vld, '0);
    chk("rst_wdt", wdt_err, '0);
    tick();
    rst = 1'b0;
    tick();
    // Issue 0x1A5 to rows 0 and 2
    inst_in = 14'h1A5; inst_row_mask = 7'b0000101; inst_vld = 1'b1;
    @(negedge clk_h);
    chk("t1_rdy", inst_rdy, 1'b1);
    inst_q.push_back('{mask: 7'b0000101, word: 14'h1A5});
    tick();
    inst_vld = 1'b0; status_sblk = 7'b0000101;
    @(negedge clk_h);
    chk("t1_en", inst_en, 7'b0000101);
    chk("t1_busy", row_busy, 7'b0000101);
    chk("t1_all_idle", all_idle, 1'b0);
    tick();
    @(negedge clk_h);
    chk("t1_en_one_cycle", inst_en, '0);
    repeat (5) tick();
    inst_in = 14'h0AA; inst_row_mask = 7'b0000001; inst_vld = 1'b1;
    @(negedge clk_h);
    chk("t2_blocked", inst_rdy, 1'b0);
    tick();
    @(negedge clk_h);
    chk("t2_blocked2", inst_rdy, 1'b0);
    tick();
    inst_in = 14'h02B; inst_row_mask = 7'b0000010;
    @(negedge clk_h);
    chk("t2_disjoint_rdy", inst_rdy, 1'b1);
    inst_q.push_back('{mask: 7'b0000010, word: 14'h02B});
    tick();
    inst_vld = 1'b0;
    @(negedge clk_h);
    chk("t2_en", inst_en, 7'b0000010);
    chk("t2_busy", row_busy, 7'b0000111);
    tick();
    tick();
    status_sblk = '0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_h);
      if (i == 1) chk("t2_guard_hold", row_busy, 7'b0000111);
      if (done) done_cnt++;
      tick();
    end
    @(negedge clk_h);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_all_idle_end", all_idle, 1'b1);
    chk("t1_busy_end", row_busy, '0);
    inst_row_mask = 7'b0000001;
    @(negedge clk_h);
    chk("t2_rdy_after_clear", inst_rdy, 1'b1);
    tick();
    inst_row_mask = '0; inst_vld = 1'b1;
    @(negedge clk_h);
    chk("drop_rdy", inst_rdy, 1'b1);
    tick();
    inst_vld = 1'b0;
    @(negedge clk_h);
    chk("drop_no_en", inst_en, '0);
    chk("drop_stay_idle", inst_rdy, 1'b1);
    tick();
    // Broadcast, rows 3 and 5 stall for three cycles
    cfg_we = 1'b1; cfg_act_mode = 1'b0; cfg_act_mask = 7'h7F;
    tick();
    cfg_we = 1'b0; act_data_in_req = 7'h7F;
    sent = 0;
    for (int i = 0; i < 12; i++) begin
      act_data_in_req = (i >= 2 && i < 5) ? 7'b1010111 : 7'h7F;
      act_in_vld = sent < 8;
      act_in = $urandom();
      @(negedge clk_h);
      chk($sformatf("bc_rdy_%0d", i), act_in_rdy, !(i >= 2 && i < 5));
      if (act_in_vld && act_in_rdy) begin
        for (int r = 0; r < N; r++) exp_q[r].push_back(act_in);
        sent++;
      end
      tick();
    end
    act_in_vld = 1'b0;
    tick();
    tick();
    for (int r = 0; r < N; r++) chk($sformatf("bc_drain_row%0d", r), exp_q[r].size(), 0);
    // Scatter over rows 0,3,5 with a config write that must be ignored mid-stream
    cfg_we = 1'b1; cfg_act_mode = 1'b1; cfg_act_mask = 7'b0101001;
    tick();
    cfg_we = 1'b0; cfg_act_mode = 1'b0; cfg_act_mask = '0;
    for (int k = 0; k < 7; k++) begin
      cfg_we = (k == 3);
      act_in_vld = k < 6;
      act_in = $urandom();
      @(negedge clk_h);
      chk($sformatf("sc_vld_%0d", k), act_data_in_vld, k > 0 ? 7'(1 << order[k-1]) : 7'b0);
      if (k < 6) begin
        chk($sformatf("sc_rdy_%0d", k), act_in_rdy, 1'b1);
        exp_q[order[k]].push_back(act_in);
      end
      tick();
    end
    cfg_we = 1'b0; act_in_vld = 1'b0;
    @(negedge clk_h);
    chk("sc_vld_drained", act_data_in_vld, '0);
    chk("sc_cfg_held", act_in_rdy, 1'b1);
    for (int r = 0; r < N; r++) chk($sformatf("sc_drain_row%0d", r), exp_q[r].size(), 0);
    tick();
    // Reset in the middle of a broadcast with an instruction in flight
    cfg_we = 1'b1; cfg_act_mode = 1'b0; cfg_act_mask = 7'h7F;
    tick();
    cfg_we = 1'b0; act_data_in_req = '0;
    act_in_vld = 1'b1; act_in = 32'hDEADBEEF;
    inst_vld = 1'b1; inst_in = 14'h03C; inst_row_mask = 7'b0000011;
    @(negedge clk_h);
    chk("rs_act_rdy", act_in_rdy, 1'b1);
    chk("rs_inst_rdy", inst_rdy, 1'b1);
    tick();
    act_in_vld = 1'b0; inst_vld = 1'b0; rst = 1'b1;
    @(negedge clk_h);
    chk("rs_vld_pre", act_data_in_vld, 7'h7F);
    chk("rs_en_pre", inst_en, 7'b0000011);
    tick();
    @(negedge clk_h);
    chk("rs_inst_en", inst_en, '0);
    chk("rs_act_vld", act_data_in_vld, '0);
    chk("rs_act_data", act_data_in, '0);
    chk("rs_inst_data", inst_data, '0);
    chk("rs_busy", row_busy, '0);
    chk("rs_all_idle", all_idle, 1'b1);
    chk("rs_done", done, 1'b0);
    tick();
    rst = 1'b0; act_data_in_req = 7'h7F; act_in_vld = 1'b1;
    @(negedge clk_h);
    chk("rs_cfg_cleared", act_in_rdy, 1'b0);
    chk("rs_fsm_idle", inst_rdy, 1'b1);
    tick();
    act_in_vld = 1'b0;
    @(negedge clk_h);
    chk("rs_no_beat", act_data_in_vld, '0);
    tick();
`ifdef SBLK_ROW_WDT_EN
    status_sblk = 7'b0010000;
    inst_in = 14'h155; inst_row_mask = 7'b0010000; inst_vld = 1'b1;
    @(negedge clk_h);
    chk("wdt_rdy", inst_rdy, 1'b1);
    inst_q.push_back('{mask: 7'b0010000, word: 14'h155});
    tick();
    inst_vld = 1'b0;
    busy_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_h);
      if (!row_busy[4]) break;
      busy_cyc++;
      tick();
    end
    chk("wdt_busy_cycles", busy_cyc, 20);
    chk("wdt_err_set", wdt_err, 7'b0010000);
    chk("wdt_busy_cleared", row_busy[4], 1'b0);
    tick();
    status_sblk = '0;
    tick();
    @(negedge clk_h);
    chk("wdt_err_sticky", wdt_err, 7'b0010000);
`endif
    chk("inst_sb_empty", inst_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
